wb_reg_file: RTL
================

# wb_reg_file

Write-back stage and architectural register file of the five-stage pipelined CPU, the consumer of the MEM/WB pipeline register outputs. Selects write-back data (ALU result or memory read data), commits it to a 32×32 register file on the rising clock edge, and serves two combinational read ports to the ID stage with same-cycle write-through bypass. Also keeps a retired-write counter for the test bench and debug.

## Interface
- `DATA_W`, 32: register and datapath width.
- `REG_N`, 32: number of registers; index width is log2(`REG_N`) = 5.
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `WB_WB`  in  2  write-back control from MEM/WB: bit 1 = MemtoReg, bit 0 = RegWrite.
- `ALUOut_WB`  in  DATA_W  ALU result from MEM/WB.
- `DataMEM_RD_WB`  in  DATA_W  data-memory read data from MEM/WB.
- `WN_WB`  in  5  destination register number.
- `RN1`, `RN2`  in  5  ID-stage read register numbers.
- `RD1`, `RD2`  out  DATA_W  read data, combinational.
- `WD`  out  DATA_W  selected write-back data, combinational; feeds the EX forwarding mux.
- `wb_valid`  out  1  combinational; 1 when a commit happens at the next edge (RegWrite=1 and WN_WB≠0).
- `wb_count`  out  32  registered count of committed writes.

## Operation
- `WD` = MemtoReg ? `DataMEM_RD_WB` : `ALUOut_WB`.
- Commit: on posedge `clk`, if `wb_valid`, then `regs[WN_WB]` ← `WD` and `wb_count` ← `wb_count`+1.
- Register 0 is hardwired zero. Writes to WN=0 are dropped, do not assert `wb_valid`, and are not counted. Reads of RN=0 return 0 regardless of bypass.
- Read port k: if `wb_valid` and `WN_WB`==RNk, return `WD` (bypass). Otherwise return `regs[RNk]`. Both ports bypass independently; RN1==RN2 is legal and both ports return the same value.
- `wb_count` wraps from 0xFFFFFFFF to 0 with no flag.
- MemtoReg=1 with RegWrite=0 has no effect on state. `WD` still reflects memory data.

## Timing
- Reset (`rst_n`=0, asynchronous): all `regs` ← 0 and `wb_count` ← 0 immediately, with no clock required.
- While reset is held, commits are suppressed. `RD1`/`RD2` still bypass combinationally from the current inputs.
- Reset asserted mid-operation discards the pending commit of that cycle. The first commit after deassertion happens at the first posedge with `rst_n`=1.
- Write latency: 1 edge to the array. Read latency: 0, combinational.
- Write-then-read in the same cycle: the reader sees the new value via bypass. The same value is held in the array from the next cycle on.
- No stall or handshake: one commit opportunity per cycle. Back-to-back writes to the same register resolve last-writer-wins.

## Structure
- Shared package `cpu_pkg`:
  - `WB_MEMTOREG`=1, `WB_REGWRITE`=0 bit indices;
  - `REG_ZERO`=5'd0;
  - `DATA_W`/`REG_IDX_W` constants, shared with the MEM/WB and EX forwarding logic.
- One sub-module, `reg_array`: a 32×DATA_W storage array with async reset, one write port, and two raw read ports. The bypass, data selection and counter stay in `wb_reg_file`.

## Test plan
- Reset: write nonzero values, assert `rst_n`=0 between edges → all `RD` read 0 and `wb_count`=0 before the next edge.
- ALU write-back: WB_WB=2'b01, ALUOut=0x0000_1234, WN=5; RN1=5 → `RD1`=0x1234 in the same cycle (bypass) and after the edge (array); `wb_count`=1.
- Load write-back: WB_WB=2'b11, DataMEM_RD=0xDEAD_BEEF, ALUOut=0x4, WN=31; RN2=31 → `RD2`=0xDEADBEEF and `WD`=0xDEADBEEF.
- $0 protection: WB_WB=2'b01, WN=0, ALUOut=0xFFFF_FFFF → `wb_valid`=0, `RD1`(RN=0)=0 before and after the edge, and `wb_count` unchanged.
- No-write: WB_WB=2'b10, WN=7 with regs[7]=0x55 → `RD1`(RN=7)=0x55 and `wb_count` unchanged.
- Dual read / same register, plus wrap: RN1=RN2=9 during a write of 0xA5 to r9 → both read 0xA5. Force `wb_count`=0xFFFFFFFF, then one commit → `wb_count`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for write-back, forwarding and register file
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_N     = 32;
  localparam int REG_IDX_W = 5;

  // Bit positions inside the 2-bit WB control bundle carried by MEM/WB.
  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_array.sv
// rtl/reg_array.sv - REG_N x DATA_W storage, one write port, two raw read ports
//
// Ports:
//   clk, rst_n           clock, async active-low reset (clears every entry)
//   i_we/i_waddr/i_wdata write port, committed on posedge
//   i_raddr1/i_raddr2    read addresses
//   o_rdata1/o_rdata2    raw array contents (no bypass, no zero forcing)
module reg_array #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr1,
  input  logic [IDX_W-1:0]  i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/wb_reg_file.sv
// rtl/wb_reg_file.sv - write-back select, architectural register file, retired-write counter
//
// Ports:
//   clk, rst_n                    pipeline clock, async active-low reset
//   WB_WB                         {MemtoReg, RegWrite} from MEM/WB
//   ALUOut_WB, DataMEM_RD_WB      write-back data candidates
//   WN_WB                         destination register
//   RN1, RN2 / RD1, RD2           ID-stage read ports, combinational with bypass
//   WD                            selected write-back data (to EX forwarding)
//   wb_valid                      a commit happens at the next edge
//   wb_count                      number of committed writes (wraps silently)
module wb_reg_file
  import cpu_pkg::WB_MEMTOREG;
  import cpu_pkg::WB_REGWRITE;
  import cpu_pkg::REG_ZERO;
  import cpu_pkg::REG_IDX_W;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_N  = cpu_pkg::REG_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           WB_WB,
  input  logic [DATA_W-1:0]    ALUOut_WB,
  input  logic [DATA_W-1:0]    DataMEM_RD_WB,
  input  logic [REG_IDX_W-1:0] WN_WB,
  input  logic [REG_IDX_W-1:0] RN1,
  input  logic [REG_IDX_W-1:0] RN2,
  output logic [DATA_W-1:0]    RD1,
  output logic [DATA_W-1:0]    RD2,
  output logic [DATA_W-1:0]    WD,
  output logic                 wb_valid,
  output logic [31:0]          wb_count
);

  logic [DATA_W-1:0] w_raw1;
  logic [DATA_W-1:0] w_raw2;
  logic [31:0]       r_wb_count;

  assign WD       = WB_WB[WB_MEMTOREG] ? DataMEM_RD_WB : ALUOut_WB;
  // $0 writes are dropped here, so the array never holds a nonzero r0.
  assign wb_valid = WB_WB[WB_REGWRITE] && (WN_WB != REG_ZERO);

  reg_array #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .IDX_W  (REG_IDX_W)
  ) u_reg_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (wb_valid),
    .i_waddr  (WN_WB),
    .i_wdata  (WD),
    .i_raddr1 (RN1),
    .i_raddr2 (RN2),
    .o_rdata1 (w_raw1),
    .o_rdata2 (w_raw2)
  );

  // r0 check first: it must read zero even if a bypass would match.
  assign RD1 = (RN1 == REG_ZERO)            ? '0 :
               (wb_valid && (WN_WB == RN1)) ? WD : w_raw1;
  assign RD2 = (RN2 == REG_ZERO)            ? '0 :
               (wb_valid && (WN_WB == RN2)) ? WD : w_raw2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_count <= '0;
    end else if (wb_valid) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign wb_count = r_wb_count;

endmodule
